// File: rtl/bsg_manycore_pkg.sv
// Shared types for the SDR row reset sequencer: phase order and phase count.
// Combinational helpers only; no latency, no backpressure.
package bsg_manycore_pkg;

    localparam int sdr_num_phases_lp = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ASSERT   = 3'd1,
        TOKEN_HI = 3'd2,
        TOKEN_LO = 3'd3,
        UP_REL   = 3'd4,
        DOWN_REL = 3'd5,
        DS_REL   = 3'd6
    } sdr_reset_state_e;

    // Phases are encoded 1..sdr_num_phases_lp in sequence order, so advancing is +1.
    function automatic sdr_reset_state_e sdr_next_phase(input sdr_reset_state_e s);
        if (s == IDLE || 3'(s) == 3'(sdr_num_phases_lp)) begin
            return IDLE;
        end
        return sdr_reset_state_e'(3'(s) + 3'd1);
    endfunction

endpackage

// File: rtl/bsg_manycore_sdr_reset_gap_counter.sv
// Per-phase hold counter: load G, count down while enabled, flag when zero.
// zero_o is combinational from the count register; no backpressure.
module bsg_manycore_sdr_reset_gap_counter #(
    parameter int gap_width_p = 8
) (
    input  logic                   core_clk_i,
    input  logic                   core_reset_n_i,
    input  logic                   load_i,
    input  logic [gap_width_p-1:0] load_val_i,
    input  logic                   en_i,
    output logic                   zero_o
);

    logic [gap_width_p-1:0] count_r;

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            count_r <= '0;
        end else if (load_i) begin
            count_r <= load_val_i;
        end else if (en_i && (count_r != '0)) begin
            count_r <= count_r - gap_width_p'(1);
        end
    end

    assign zero_o = (count_r == '0);

endmodule

// File: rtl/bsg_manycore_sdr_row_reset_seq.sv
// SDR row link-reset bring-up sequencer; outputs registered, ASSERT visible 1 cycle after start.
// No backpressure: start is ignored while busy, abort wins over everything while busy.
module bsg_manycore_sdr_row_reset_seq
    import bsg_manycore_pkg::*;
#(
    parameter int num_channels_p = 16,
    parameter int gap_width_p    = 8
) (
    input  logic                      core_clk_i,
    input  logic                      core_reset_n_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [num_channels_p-1:0] channel_mask_i,
    input  logic [gap_width_p-1:0]    gap_cycles_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [num_channels_p-1:0] async_uplink_reset_o,
    output logic [num_channels_p-1:0] async_downlink_reset_o,
    output logic [num_channels_p-1:0] async_downstream_reset_o,
    output logic [num_channels_p-1:0] async_token_reset_o
);

    sdr_reset_state_e state_r, state_n;

    logic [num_channels_p-1:0] mask_r;
    logic [gap_width_p-1:0]    gap_r;
    logic                      armed_r;

    logic                      in_seq;
    logic                      start_acc;
    logic                      abort_acc;
    logic                      gap_zero;
    logic                      phase_end;
    logic                      cnt_load;
    logic [gap_width_p-1:0]    cnt_load_val;
    logic [num_channels_p-1:0] mask_eff;

    logic busy_r, done_r;
    logic busy_n, done_n;

    assign in_seq    = (state_r != IDLE);
    assign start_acc = !in_seq && armed_r && start_i;
    assign abort_acc = in_seq && abort_i;
    assign phase_end = in_seq && gap_zero;

    // The mask must steer outputs on the accepting edge itself, before mask_r holds it.
    assign mask_eff = start_acc ? channel_mask_i : mask_r;

    // State register
    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        if (abort_acc) begin
            state_n = IDLE;
        end else if (start_acc) begin
            state_n = ASSERT;
        end else if (phase_end) begin
            state_n = sdr_next_phase(state_r);
        end
    end

    // Blocks acceptance on the first edge after reset release.
    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= 1'b1;
        end
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            mask_r <= '0;
            gap_r  <= '0;
        end else if (start_acc) begin
            mask_r <= channel_mask_i;
            gap_r  <= gap_cycles_i;
        end
    end

    assign cnt_load     = start_acc || abort_acc || phase_end;
    assign cnt_load_val = (state_n == IDLE) ? '0 :
                          (start_acc ? gap_cycles_i : gap_r);

    bsg_manycore_sdr_reset_gap_counter #(
        .gap_width_p(gap_width_p)
    ) gap_counter (
        .core_clk_i    (core_clk_i),
        .core_reset_n_i(core_reset_n_i),
        .load_i        (cnt_load),
        .load_val_i    (cnt_load_val),
        .en_i          (in_seq),
        .zero_o        (gap_zero)
    );

    // Output logic: status flags
    always_comb begin
        busy_n = (state_n != IDLE);
        done_n = phase_end && (state_r == DS_REL) && !abort_acc;
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    assign busy_o = busy_r;
    assign done_o = done_r;

    // Output logic: per-channel resets. Each phase touches one signal; the rest hold.
    for (genvar i = 0; i < num_channels_p; i++) begin : g_ch
        logic up_r, down_r, ds_r, tok_r;
        logic up_n, down_n, ds_n, tok_n;

        always_comb begin
            up_n   = up_r;
            down_n = down_r;
            ds_n   = ds_r;
            tok_n  = tok_r;
            if (abort_acc || ((state_n != IDLE) && !mask_eff[i])) begin
                up_n   = 1'b1;
                down_n = 1'b1;
                ds_n   = 1'b1;
                tok_n  = 1'b0;
            end else if (mask_eff[i]) begin
                case (state_n)
                    ASSERT: begin
                        up_n   = 1'b1;
                        down_n = 1'b1;
                        ds_n   = 1'b1;
                        tok_n  = 1'b0;
                    end
                    TOKEN_HI: tok_n  = 1'b1;
                    TOKEN_LO: tok_n  = 1'b0;
                    UP_REL:   up_n   = 1'b0;
                    DOWN_REL: down_n = 1'b0;
                    DS_REL:   ds_n   = 1'b0;
                    default:  begin end
                endcase
            end
        end

        always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
            if (!core_reset_n_i) begin
                up_r   <= 1'b1;
                down_r <= 1'b1;
                ds_r   <= 1'b1;
                tok_r  <= 1'b0;
            end else begin
                up_r   <= up_n;
                down_r <= down_n;
                ds_r   <= ds_n;
                tok_r  <= tok_n;
            end
        end

        assign async_uplink_reset_o[i]     = up_r;
        assign async_downlink_reset_o[i]   = down_r;
        assign async_downstream_reset_o[i] = ds_r;
        assign async_token_reset_o[i]      = tok_r;
    end

endmodule

// File: tb/tb_bsg_manycore_sdr_row_reset_seq.sv
// Bench for the SDR row reset sequencer: elapsed-cycle reference model plus done_o scoreboard.
module tb_bsg_manycore_sdr_row_reset_seq;

    localparam int N = 16;
    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] mask  = '0;
    logic [W-1:0] gap   = '0;
    logic         busy, done;
    logic [N-1:0] up, dn, ds, tk;

    always #5 clk = ~clk;

    bsg_manycore_sdr_row_reset_seq #(
        .num_channels_p(N),
        .gap_width_p   (W)
    ) dut (
        .core_clk_i              (clk),
        .core_reset_n_i          (rst_n),
        .start_i                 (start),
        .abort_i                 (abort),
        .channel_mask_i          (mask),
        .gap_cycles_i            (gap),
        .busy_o                  (busy),
        .done_o                  (done),
        .async_uplink_reset_o    (up),
        .async_downlink_reset_o  (dn),
        .async_downstream_reset_o(ds),
        .async_token_reset_o     (tk)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model: a run is "elapsed cycles since accept"; phase = elapsed / (G+1).
    bit           m_run   = 1'b0;
    bit           m_armed = 1'b0;
    bit           m_done  = 1'b0;
    bit           pending = 1'b0;
    int           m_k     = 0;
    int           m_g     = 0;
    logic [N-1:0] m_mask  = '0;
    logic [N-1:0] h_up    = '1;
    logic [N-1:0] h_dn    = '1;
    logic [N-1:0] h_ds    = '1;
    logic [N-1:0] h_tk    = '0;
    int           sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   = 1'b0;
            m_armed = 1'b0;
            m_done  = 1'b0;
            h_up = '1; h_dn = '1; h_ds = '1; h_tk = '0;
            if (pending) begin
                void'(sb.pop_back());
                pending = 1'b0;
            end
        end else begin
            cyc++;
            m_done = 1'b0;
            if (m_run) begin
                if (abort) begin
                    m_run = 1'b0;
                    h_up = '1; h_dn = '1; h_ds = '1; h_tk = '0;
                    void'(sb.pop_back());
                    pending = 1'b0;
                end else begin
                    m_k++;
                    if (m_k == 6 * (m_g + 1)) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                        h_up = ~m_mask; h_dn = ~m_mask; h_ds = ~m_mask; h_tk = '0;
                        pending = 1'b0;
                    end
                end
            end else if (start && m_armed) begin
                m_run  = 1'b1;
                m_k    = 0;
                m_g    = int'(gap);
                m_mask = mask;
                sb.push_back(cyc + 6 * (m_g + 1));
                pending = 1'b1;
            end
            m_armed = 1'b1;
        end
    end

    // Monitor: full output compare every cycle, scoreboard pop on each done_o.
    always @(negedge clk) begin
        logic [N-1:0] e_up, e_dn, e_ds, e_tk;
        int p;
        int e;
        if (chk_en) begin
            if (m_run) begin
                p    = m_k / (m_g + 1);
                e_up = (p < 3) ? '1 : ~m_mask;
                e_dn = (p < 4) ? '1 : ~m_mask;
                e_ds = (p < 5) ? '1 : ~m_mask;
                e_tk = (p == 1) ? m_mask : '0;
            end else begin
                e_up = h_up; e_dn = h_dn; e_ds = h_ds; e_tk = h_tk;
            end
            total++;
            if ({busy, done, up, dn, ds, tk} !== {m_run, m_done, e_up, e_dn, e_ds, e_tk}) begin
                bad++;
                $display("FAIL outputs cyc=%0d got busy=%b done=%b up=%h dn=%h ds=%h tk=%h want busy=%b done=%b up=%h dn=%h ds=%h tk=%h",
                         cyc, busy, done, up, dn, ds, tk, m_run, m_done, e_up, e_dn, e_ds, e_tk);
            end
            if (done === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected cyc=%0d got done=1 want no pending run", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e != cyc) begin
                        bad++;
                        $display("FAIL done_cycle got=%0d want=%0d", cyc, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [W-1:0] g, input logic [N-1:0] m);
        gap   = g;
        mask  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (m_run && n < bound) begin
            step();
            n++;
        end
        total++;
        if (m_run) begin
            bad++;
            $display("FAIL wait_idle got still running after %0d cycles want idle", bound);
        end
    endtask

    task automatic wait_k(input int target, input int bound);
        int n = 0;
        while (!(m_run && m_k >= target) && n < bound) begin
            step();
            n++;
        end
        total++;
        if (!(m_run && m_k >= target)) begin
            bad++;
            $display("FAIL wait_k got k=%0d run=%b want k>=%0d", m_k, m_run, target);
        end
    endtask

    initial begin
        repeat (3) step();
        chk_en = 1'b1;
        step();

        // Start held across release: first edge must be ignored, second accepted.
        gap = W'(3); mask = '1; start = 1'b1; rst_n = 1'b1;
        step();
        step();
        start = 1'b0;
        wait_idle(100);
        repeat (2) step();

        pulse_start(W'(0), 16'h00F0);
        wait_idle(50);
        repeat (2) step();

        // Abort in UP_REL, with a coincident start that must lose.
        pulse_start(W'(5), '1);
        wait_k(20, 100);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (2) step();

        // Start while busy and mid-run input changes must not disturb the run.
        pulse_start(W'(2), 16'hA5A5);
        repeat (4) step();
        start = 1'b1; gap = W'(7); mask = 16'h0F0F;
        step();
        start = 1'b0;
        wait_idle(100);
        repeat (2) step();

        // Reset during TOKEN_HI.
        pulse_start(W'(4), '1);
        wait_k(6, 50);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, up, dn, ds, tk} !== {1'b0, 1'b0, {N{1'b1}}, {N{1'b1}}, {N{1'b1}}, {N{1'b0}}}) begin
            bad++;
            $display("FAIL reset_immediate got busy=%b done=%b up=%h dn=%h ds=%h tk=%h want 0 0 ffff ffff ffff 0000",
                     busy, done, up, dn, ds, tk);
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        pulse_start(8'hFF, 16'h3C5A);
        wait_idle(2000);
        repeat (2) step();

        pulse_start(W'(1), '0);
        wait_idle(50);
        repeat (2) step();

        for (int r = 0; r < 12; r++) begin
            pulse_start(W'($urandom_range(0, 12)), N'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                wait_k(int'($urandom_range(0, 6 * (m_g + 1) - 1)), 200);
                abort = 1'b1;
                step();
                abort = 1'b0;
            end else begin
                for (int n = 0; n < 200 && m_run; n++) begin
                    start = 1'b1 & 1'($urandom_range(0, 1));
                    gap   = W'($urandom);
                    mask  = N'($urandom);
                    step();
                end
                start = 1'b0;
            end
            wait_idle(200);
            repeat (2) step();
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got %0d pending done events want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_sdr_row_reset_seq.md
BSG_MANYCORE_SDR_ROW_RESET_SEQ -- requirements
Module: bsg_manycore_sdr_row_reset_seq

Interface
REQ-001 SHALL have parameter num_channels_p, default 16; number of SDR channels in the row.
REQ-002 SHALL have parameter gap_width_p, default 8; width of the per-phase hold count.
REQ-003 SHALL have port core_clk_i, input, 1; the single clock.
REQ-004 SHALL have port core_reset_n_i, input, 1; reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1; request to run the bring-up sequence.
REQ-006 SHALL have port abort_i, input, 1; cancels a running sequence.
REQ-007 SHALL have port channel_mask_i, input, num_channels_p; 1 means the channel is included in the sequence.
REQ-008 SHALL have port gap_cycles_i, input, gap_width_p; G, where each phase lasts G+1 cycles.
REQ-009 SHALL have port busy_o, output, 1; high while a sequence is running.
REQ-010 SHALL have port done_o, output, 1; one-cycle completion pulse.
REQ-011 SHALL have ports async_uplink_reset_o, async_downlink_reset_o and async_downstream_reset_o, each output, num_channels_p; per-channel link resets, active-high.
REQ-012 SHALL have port async_token_reset_o, output, num_channels_p; per-channel token reset.

Function
REQ-013 SHALL implement states IDLE, ASSERT, TOKEN_HI, TOKEN_LO, UP_REL, DOWN_REL and DS_REL.
REQ-014 SHALL drive, for each included channel, per state:
- ASSERT: uplink, downlink and downstream = 1; token = 0.
- TOKEN_HI: token = 1.
- TOKEN_LO: token = 0.
- UP_REL: uplink = 0.
- DOWN_REL: downlink = 0.
- DS_REL: downstream = 0.
- Every signal not named for a state keeps its value from the previous state.
REQ-015 SHALL keep excluded channels at uplink, downlink and downstream = 1 and token = 0 from the cycle after start is accepted.
REQ-016 SHALL accept start_i only in IDLE; start_i while busy SHALL be ignored.
REQ-017 SHALL latch channel_mask_i and gap_cycles_i on the accepting edge; later input changes SHALL have no effect until the next start.
REQ-018 SHALL register all outputs.
REQ-019 SHALL make the ASSERT values visible in the cycle after the start edge, with busy_o = 1 in that same cycle.
REQ-020 SHALL hold each state for exactly G+1 cycles, then advance in the order of REQ-013.
REQ-021 SHALL, after DS_REL, enter IDLE with done_o = 1 and busy_o = 0 for exactly one cycle, 6*(G+1) cycles after ASSERT first becomes visible.
REQ-022 SHALL leave released channels released in IDLE until the next start.
REQ-023 SHALL, on a new start from IDLE, re-assert previously released included channels in ASSERT.
REQ-024 SHALL, on abort_i while busy, go to IDLE next cycle with all included channels at uplink, downlink and downstream = 1 and token = 0, and done_o = 0.
REQ-025 SHALL ignore abort_i in IDLE.
REQ-026 SHALL give abort_i priority when start_i and abort_i arrive together while busy.
REQ-027 SHALL, when G = 0, make each phase last 1 cycle (6-cycle sequence); G = all-ones SHALL give 2^gap_width_p cycles per phase with no wrap error.
REQ-028 SHALL, with an all-zero mask, still run the full timing and pulse done_o, while all outputs stay at their safe values.

Reset
REQ-029 SHALL, while core_reset_n_i is low, immediately force: state IDLE; uplink, downlink and downstream = all ones; token = all zeros; busy_o = 0; done_o = 0; counter = 0.
REQ-030 SHALL, if reset is asserted mid-sequence, abandon the sequence with no done_o pulse, and require a new start_i after reset is released.
REQ-031 SHALL NOT accept start_i in the first cycle after reset is released.

Structure
REQ-032 SHALL take the state enum typedef and the phase-count constant (6) from a shared package (bsg_manycore_pkg).
REQ-033 SHALL place the per-phase hold counter in one sub-module, bsg_manycore_sdr_reset_gap_counter: load G, count down, flag on zero, gap_width_p-bit.
REQ-034 SHALL generate per-channel output bits from a generate loop over num_channels_p.

Verification
REQ-035 SHALL cover basic sequencing: G = 3, mask = 16'hFFFF, start pulse -> each phase 4 cycles; done_o at cycle 24 after ASSERT visible; finally uplink, downlink and downstream = 0, token = 0.
REQ-036 SHALL cover masking: mask = 16'h00F0, G = 0 -> only channels 4-7 release; others hold 1/1/1/0; done_o 6 cycles after ASSERT.
REQ-037 SHALL cover abort: abort_i during UP_REL with G = 5 -> next cycle IDLE, included channels 1/1/1/0, no done_o.
REQ-038 SHALL cover start-while-busy and input latching: start_i while busy, plus a mid-run change of gap_cycles_i 2 -> 7 -> no restart; timing stays 3 cycles per phase.
REQ-039 SHALL cover reset mid-sequence: core_reset_n_i low during TOKEN_HI -> outputs all-ones, token 0, busy 0 immediately; no done_o.
REQ-040 SHALL cover maximum gap: G = 8'hFF -> each phase 256 cycles; done_o at cycle 1536.
